// File: rtl/run_detect_pkg.sv
// Shared definitions for the run-of-ones detection scheduler:
// FSM encodings, a constant-safe clog2 and the default run length.
package run_detect_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int DEFAULT_RUN_LEN = 3;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_SHIFT = SHIFT,
        S_DONE  = DONE
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/run_detector.sv
// Serial run-of-ones detector: a saturating count of preceding 1s and a
// Mealy detect that fires on the bit completing a run of RUN_LEN ones.
module run_detector
    import run_detect_pkg::*;
#(
    parameter int RUN_LEN = DEFAULT_RUN_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic detect
);

    localparam int            RW  = clog2(RUN_LEN);
    localparam logic [RW-1:0] SAT = RW'(RUN_LEN - 1);

    logic [RW-1:0] r_run;

    // Saturating at RUN_LEN-1 lets longer runs keep firing every bit (overlap).
    assign detect = en & din & (r_run == SAT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run <= '0;
        end else if (clr) begin
            r_run <= '0;
        end else if (en) begin
            if (!din) begin
                r_run <= '0;
            end else if (r_run != SAT) begin
                r_run <= r_run + 1'b1;
            end
        end
    end

endmodule

// File: rtl/run_detect_sched.sv
// Round-robin scheduler feeding one serial run detector from N_REQ
// parallel word sources; returns the per-word detect count with the source id.
module run_detect_sched
    import run_detect_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int WORD_W  = 8,
    parameter  int RUN_LEN = DEFAULT_RUN_LEN,
    localparam int IDW     = clog2(N_REQ),
    localparam int CNT_W   = clog2(WORD_W + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*WORD_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic [CNT_W-1:0]        rsp_count,
    output logic                    rsp_any,
    input  logic                    rsp_ready
);

    localparam int             BCW      = clog2(WORD_W);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_W - 1);

    state_t             r_state;
    state_t             w_next;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_id;
    logic [WORD_W-1:0]  r_shift;
    logic [BCW-1:0]     r_bitcnt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_rsp_count;
    logic               r_rsp_any;

    logic [IDW-1:0]     w_gnt_id;
    logic               w_found;
    logic               w_accept;
    logic               w_shift_en;
    logic               w_last;
    logic               w_detect;
    logic [CNT_W-1:0]   w_count_nxt;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
        return IDW'((int'(base) + off) % N_REQ);
    endfunction

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && req_valid[rr_idx(r_rr_ptr, k)]) begin
                w_found  = 1'b1;
                w_gnt_id = rr_idx(r_rr_ptr, k);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = '0;
        w_accept   = 1'b0;
        w_shift_en = 1'b0;
        w_last     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    req_ready = N_REQ'(1) << w_gnt_id;
                    w_accept  = 1'b1;
                    w_next    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shift_en = 1'b1;
                if (r_bitcnt == LAST_BIT) begin
                    w_last = 1'b1;
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    run_detector #(
        .RUN_LEN (RUN_LEN)
    ) u_det (
        .clk    (clk),
        .reset  (reset),
        .clr    (w_accept),
        .en     (w_shift_en),
        .din    (r_shift[WORD_W-1]),
        .detect (w_detect)
    );

    // The final bit's detect is folded in on the same edge that enters DONE.
    assign w_count_nxt = r_count + CNT_W'(w_detect);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_count     <= '0;
            r_rsp_count <= '0;
            r_rsp_any   <= 1'b0;
        end else if (w_accept) begin
            r_shift  <= req_data[w_gnt_id*WORD_W +: WORD_W];
            r_id     <= w_gnt_id;
            r_bitcnt <= '0;
            r_count  <= '0;
            r_rr_ptr <= rr_idx(w_gnt_id, 1);
        end else if (w_shift_en) begin
            r_shift  <= {r_shift[WORD_W-2:0], 1'b0};
            r_bitcnt <= r_bitcnt + 1'b1;
            r_count  <= w_count_nxt;
            if (w_last) begin
                r_rsp_count <= w_count_nxt;
                r_rsp_any   <= (w_count_nxt != '0);
            end
        end
    end

    assign rsp_valid = (r_state == S_DONE);
    assign rsp_id    = r_id;
    assign rsp_count = r_rsp_count;
    assign rsp_any   = r_rsp_any;

endmodule
